// File: rtl/hasti_poci_bridge_if.sv
// Bus bundles for the HASTI (AHB-Lite) side and the POCI (APB3) side of the bridge.
// The master modport belongs to whichever agent initiates transfers on that bus.
interface hasti_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic                  hwrite;
   logic [2:0]            hsize;
   logic [1:0]            htrans;
   logic [DATA_WIDTH-1:0] hwdata;
   logic [DATA_WIDTH-1:0] hrdata;
   logic                  hready;
   logic                  hresp;

   modport master (output hsel, haddr, hwrite, hsize, htrans, hwdata,
                   input  hrdata, hready, hresp);
   modport slave  (input  hsel, haddr, hwrite, hsize, htrans, hwdata,
                   output hrdata, hready, hresp);
endinterface

interface poci_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] paddr;
   logic                  pwrite;
   logic                  psel;
   logic                  penable;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (output paddr, pwrite, psel, penable, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  paddr, pwrite, psel, penable, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/hasti_poci_bridge.sv
// HASTI-to-POCI bridge: each accepted HASTI transfer becomes one POCI SETUP/ACCESS
// transfer, with hready stalls, two-cycle ERROR responses and a wait-state timeout.
module hasti_poci_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic   pclk,
   input  logic   presetn,
   hasti_if.slave hasti,
   poci_if.master poci
);

   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam bit               TO_EN    = (TIMEOUT != 0);

   typedef enum logic [2:0] {
      S_IDLE, S_DATA, S_SETUP, S_ACCESS, S_ERR1, S_RESP
   } state_e;

   state_e                state_q, state_d;
   logic                  hready_q, hready_d;
   logic                  hresp_q, hresp_d;
   logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  accept;

   // hsize and the SEQ/NONSEQ distinction do not change what the bridge does.
   logic unused_inputs;
   assign unused_inputs = ^{hasti.hsize, hasti.htrans[0]};

   assign accept = hasti.hsel & hasti.htrans[1] & hready_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path can infer a latch.
      state_d   = state_q;
      hready_d  = hready_q;
      hresp_d   = hresp_q;
      hrdata_d  = hrdata_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         S_IDLE, S_RESP: begin
            hready_d  = 1'b1;
            hresp_d   = 1'b0;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            state_d   = S_IDLE;
            if (accept) begin
               state_d  = S_DATA;
               hready_d = 1'b0;
               paddr_d  = hasti.haddr;
               pwrite_d = hasti.hwrite;
            end
         end
         S_DATA: begin
            if (pwrite_q) pwdata_d = hasti.hwdata;
            cnt_d   = '0;
            psel_d  = 1'b1;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            penable_d = 1'b1;
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            cnt_d = cnt_q + 1'b1;
            if (poci.pready) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               if (poci.pslverr) begin
                  state_d = S_ERR1;
                  hresp_d = 1'b1;
               end else begin
                  state_d  = S_RESP;
                  hready_d = 1'b1;
                  if (!pwrite_q) hrdata_d = poci.prdata;
               end
            end else if (TO_EN && cnt_q == CNT_LAST) begin
               // Peripheral hung: abandon the POCI transfer and report ERROR upstream.
               psel_d    = 1'b0;
               penable_d = 1'b0;
               state_d   = S_ERR1;
               hresp_d   = 1'b1;
            end
         end
         S_ERR1: begin
            state_d  = S_RESP;
            hready_d = 1'b1;
            hresp_d  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q   <= S_IDLE;
         hready_q  <= 1'b1;
         hresp_q   <= 1'b0;
         hrdata_q  <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         hready_q  <= hready_d;
         hresp_q   <= hresp_d;
         hrdata_q  <= hrdata_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         cnt_q     <= cnt_d;
      end
   end

   assign hasti.hready = hready_q;
   assign hasti.hresp  = hresp_q;
   assign hasti.hrdata = hrdata_q;
   assign poci.psel    = psel_q;
   assign poci.penable = penable_q;
   assign poci.pwrite  = pwrite_q;
   assign poci.paddr   = paddr_q;
   assign poci.pwdata  = pwdata_q;

endmodule

// File: tb/tb_hasti_poci_bridge.sv
// Randomized scoreboard bench for hasti_poci_bridge: a HASTI master driver, a POCI
// peripheral model with planned wait states/errors, and a response monitor.
module tb_hasti_poci_bridge;

   localparam int TIMEOUT = 4;

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          waits;
      bit          err;
      bit          exp_resp;
      int          exp_lat;
      logic [31:0] exp_hrdata;
   } txn_t;

   typedef struct {
      bit   idle;
      txn_t t;
   } stim_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   hasti_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) hasti ();
   poci_if  #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) poci ();

   hasti_poci_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
      .pclk    (clk),
      .presetn (rst_n),
      .hasti   (hasti.slave),
      .poci    (poci.master)
   );

   int          checks = 0;
   int          failures = 0;
   stim_t       stim_q[$];
   txn_t        sb_q[$];
   txn_t        plan_q[$];
   logic [31:0] model_hrdata = '0;
   bit          addr_done_rdy = 1'b1;
   bit          drv_active = 1'b0;
   txn_t        drv_txn;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a transfer spends DATA + SETUP + its ACCESS cycles (+ ERR1 on error)
   // with hready low; ACCESS lasts waits+1 cycles unless the timeout cuts it at TIMEOUT.
   task automatic accept(input txn_t t);
      bit timed_out;
      int access;
      timed_out  = (TIMEOUT != 0) && (t.waits >= TIMEOUT);
      access     = timed_out ? TIMEOUT : t.waits + 1;
      t.exp_resp = timed_out || t.err;
      t.exp_lat  = 2 + access + (t.exp_resp ? 1 : 0);
      if (!t.exp_resp && !t.write) model_hrdata = t.rdata;
      t.exp_hrdata = model_hrdata;
      sb_q.push_back(t);
      plan_q.push_back(t);
   endtask

   function automatic stim_t mk(input bit write, input logic [31:0] addr, input logic [31:0] wdata,
                                input int waits, input bit err, input logic [31:0] rdata);
      stim_t s;
      s.idle    = 1'b0;
      s.t       = '{default: '0};
      s.t.write = write;
      s.t.addr  = addr;
      s.t.wdata = wdata;
      s.t.waits = waits;
      s.t.err   = err;
      s.t.rdata = rdata;
      return s;
   endfunction

   task automatic drive_idle();
      hasti.haddr = $urandom;
      hasti.hwrite = 1'($urandom);
      hasti.hsize = 3'($urandom);
      if ($urandom_range(0, 1) == 0) begin
         hasti.hsel   = 1'b0;
         hasti.htrans = 2'($urandom);
      end else begin
         hasti.hsel   = 1'b1;
         hasti.htrans = {1'b0, 1'($urandom)};
      end
   endtask

   // One HASTI master cycle: the address phase on the bus completes at an edge with hready=1.
   task automatic drive_cycle();
      stim_t s;
      @(posedge clk);
      #1;
      if (addr_done_rdy) begin
         if (drv_active) begin
            hasti.hwdata = drv_txn.write ? drv_txn.wdata : $urandom;
            accept(drv_txn);
         end
         drv_active = 1'b0;
         if (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            if (s.idle) drive_idle();
            else begin
               hasti.hsel   = 1'b1;
               hasti.haddr  = s.t.addr;
               hasti.hwrite = s.t.write;
               hasti.hsize  = 3'($urandom);
               hasti.htrans = {1'b1, 1'($urandom)};
               drv_txn      = s.t;
               drv_active   = 1'b1;
            end
         end else drive_idle();
      end
      addr_done_rdy = hasti.hready;
   endtask

   task automatic run_until_drained(input int budget);
      int n = 0;
      while ((stim_q.size() > 0 || drv_active || sb_q.size() > 0) && n < budget) begin
         drive_cycle();
         n++;
      end
      check("drain_within_budget", 32'(n < budget), 32'd1);
      repeat (3) drive_cycle();
   endtask

   // Response monitor: counts hready-low cycles and scores each completed transfer.
   initial begin
      int lowcnt = 0;
      bit last_low_hresp = 1'b0;
      txn_t e;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            lowcnt = 0;
         end else if (!hasti.hready) begin
            lowcnt++;
            last_low_hresp = hasti.hresp;
         end else if (lowcnt > 0) begin
            if (sb_q.size() == 0) check("unexpected_response", 32'(lowcnt), 32'd0);
            else begin
               e = sb_q.pop_front();
               check("latency", 32'(lowcnt), 32'(e.exp_lat));
               check("hresp", 32'(hasti.hresp), 32'(e.exp_resp));
               check("hrdata", hasti.hrdata, e.exp_hrdata);
               if (e.exp_resp) check("err1_hresp", 32'(last_low_hresp), 32'd1);
            end
            lowcnt = 0;
         end else begin
            check("idle_hresp", 32'(hasti.hresp), 32'd0);
         end
      end
   end

   // POCI peripheral: follows the plan of the transfer it sees in SETUP.
   initial begin
      txn_t cur;
      int   acc_k = 0;
      poci.pready = 1'b0;
      poci.pslverr = 1'b0;
      poci.prdata = '0;
      cur = '{default: '0};
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            acc_k = 0;
            poci.pready = 1'b0;
         end else if (poci.psel && !poci.penable) begin
            if (plan_q.size() == 0) check("unplanned_setup", 32'd1, 32'd0);
            else cur = plan_q.pop_front();
            check("paddr", poci.paddr, cur.addr);
            check("pwrite", 32'(poci.pwrite), 32'(cur.write));
            if (cur.write) check("pwdata", poci.pwdata, cur.wdata);
            acc_k = 0;
            poci.pready = 1'($urandom);
            poci.pslverr = 1'($urandom);
            poci.prdata = $urandom;
         end else if (poci.psel && poci.penable) begin
            check("access_within_timeout", 32'(acc_k < TIMEOUT), 32'd1);
            check("paddr_stable", poci.paddr, cur.addr);
            if (cur.write) check("pwdata_stable", poci.pwdata, cur.wdata);
            if (acc_k == cur.waits) begin
               poci.pready = 1'b1;
               poci.pslverr = cur.err;
               poci.prdata = cur.rdata;
            end else begin
               poci.pready = 1'b0;
               poci.pslverr = 1'($urandom);
               poci.prdata = $urandom;
            end
            acc_k++;
         end else begin
            poci.pready = 1'($urandom);
            poci.pslverr = 1'($urandom);
            poci.prdata = $urandom;
         end
      end
   end

   initial begin
      int  n;
      bit  seen;
      hasti.hsel = 1'b0;
      hasti.haddr = '0;
      hasti.hwrite = 1'b0;
      hasti.hsize = 3'd2;
      hasti.htrans = 2'b00;
      hasti.hwdata = '0;

      #2 rst_n = 1'b0;
      #1;
      check("rst_hready", 32'(hasti.hready), 32'd1);
      check("rst_hresp", 32'(hasti.hresp), 32'd0);
      check("rst_hrdata", hasti.hrdata, 32'd0);
      check("rst_psel", 32'(poci.psel), 32'd0);
      check("rst_penable", 32'(poci.penable), 32'd0);
      check("rst_pwrite", 32'(poci.pwrite), 32'd0);
      check("rst_paddr", poci.paddr, 32'd0);
      check("rst_pwdata", poci.pwdata, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Directed: zero-wait write, 2-wait read, back-to-back pair, slave error, timeout.
      stim_q.push_back(mk(1'b1, 32'h10, 32'h0000_00A5, 0, 1'b0, 32'h0));
      stim_q.push_back(mk(1'b0, 32'h20, 32'h0, 2, 1'b0, 32'h0000_03FF));
      stim_q.push_back(mk(1'b1, 32'h0, 32'hCAFE_0001, 0, 1'b0, 32'h0));
      stim_q.push_back(mk(1'b0, 32'h0, 32'h0, 0, 1'b0, 32'h1234_5678));
      stim_q.push_back(mk(1'b0, 32'h44, 32'h0, 0, 1'b1, 32'hDEAD_BEEF));
      stim_q.push_back(mk(1'b0, 32'h48, 32'h0, 10, 1'b0, 32'hBAD0_BAD0));
      stim_q.push_back(mk(1'b1, 32'h4C, 32'h5555_AAAA, 1, 1'b0, 32'h0));
      run_until_drained(200);

      // Randomized mix with idle/BUSY/unselected cycles interleaved.
      for (int i = 0; i < 200; i++) begin
         stim_t s;
         if ($urandom_range(0, 3) == 0) begin
            s.idle = 1'b1;
            s.t = '{default: '0};
         end else begin
            s = mk(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 5)),
                   ($urandom_range(0, 5) == 0), $urandom);
         end
         stim_q.push_back(s);
      end
      run_until_drained(4000);

      // Reset during ACCESS abandons the transfer with no response.
      stim_q.push_back(mk(1'b0, 32'h80, 32'h0, 3, 1'b0, 32'h7777_7777));
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
         drive_cycle();
         seen = poci.penable;
         n++;
      end
      check("reached_access", 32'(seen), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_psel", 32'(poci.psel), 32'd0);
      check("arst_penable", 32'(poci.penable), 32'd0);
      check("arst_hready", 32'(hasti.hready), 32'd1);
      check("arst_hresp", 32'(hasti.hresp), 32'd0);
      sb_q.delete();
      plan_q.delete();
      stim_q.delete();
      drv_active = 1'b0;
      model_hrdata = '0;
      hasti.hsel = 1'b0;
      hasti.htrans = 2'b00;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      addr_done_rdy = 1'b1;
      stim_q.push_back(mk(1'b1, 32'h90, 32'h0BAD_F00D, 1, 1'b0, 32'h0));
      stim_q.push_back(mk(1'b0, 32'h94, 32'h0, 0, 1'b0, 32'h600D_CAFE));
      run_until_drained(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hasti_poci_bridge.md
Name: hasti_poci_bridge

Overview:
- Single-slave bridge from the CPU's HASTI (AHB-Lite) bus to the POCI (APB3) peripheral bus.
- Sits directly upstream of the POCI peripherals, such as the LED/7-segment driver.
- Converts each pipelined HASTI transfer into one POCI SETUP/ACCESS transfer.
- Stalls the CPU with hready until the peripheral completes, and maps pslverr to a two-cycle HASTI ERROR response.
- Provides a wait-state timeout so a hung peripheral cannot lock the CPU.

Parameters:
ADDR_WIDTH, 32, width of haddr and paddr
DATA_WIDTH, 32, width of the write and read data buses
TIMEOUT, 255, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
pclk  in  1  bus clock, rising edge
presetn  in  1  asynchronous active-low reset
hsel  in  1  bridge selected by the HASTI decoder
haddr  in  ADDR_WIDTH  HASTI address, address phase
hwrite  in  1  1=write, address phase
hsize  in  3  transfer size; accepted but not forwarded (POCI has no strobes)
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwdata  in  DATA_WIDTH  write data, data phase
hrdata  out  DATA_WIDTH  read data, registered
hready  out  1  transfer done / bridge ready
hresp  out  1  0 OKAY, 1 ERROR
paddr  out  ADDR_WIDTH  POCI address
pwrite  out  1  POCI direction
psel  out  1  POCI select
penable  out  1  POCI enable
pwdata  out  DATA_WIDTH  POCI write data
prdata  in  DATA_WIDTH  POCI read data
pready  in  1  POCI wait-state control
pslverr  in  1  POCI error

Behaviour:
- One clock, pclk. Reset presetn is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - state IDLE
  - hready=1, hresp=0, hrdata=0
  - psel=0, penable=0, pwrite=0
  - paddr=0, pwdata=0
  - timeout counter=0
- Reset asserted mid-transfer abandons the transfer: psel and penable fall asynchronously. No response is given.
- Accept condition: hsel & htrans[1] & hready while in IDLE or RESP. On accept, latch haddr into paddr and hwrite into pwrite.
- IDLE/BUSY transfers (htrans[1]=0) are ignored and get a zero-wait OKAY.
- States:
  - IDLE: hready=1, hresp=0. Accept -> DATA.
  - DATA: first data-phase cycle, hready=0. Capture hwdata into pwdata (for writes only). -> SETUP.
  - SETUP: psel=1, penable=0, hready=0. -> ACCESS.
  - ACCESS: psel=1, penable=1, hready=0. Counter increments each cycle.
    - pready & ~pslverr -> RESP with OKAY. On reads, capture prdata into hrdata.
    - pready & pslverr -> ERR1.
    - ~pready & TIMEOUT!=0 & counter==TIMEOUT-1 -> ERR1. psel and penable drop.
  - ERR1: psel=0, hready=0, hresp=1. -> RESP with hresp held 1.
  - RESP: psel=0, penable=0, hready=1. hresp=1 only if arriving from ERR1.
    - Accept in the same cycle -> DATA (back-to-back pipelining).
    - Otherwise -> IDLE.
- Outputs in ACCESS:
  - The counter clears on entry to SETUP.
  - paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
- Latency (hready low cycles per transfer) = 3 + number of pready-low ACCESS cycles.
  - Error responses add one extra cycle.
- hrdata holds its last captured value between reads. It is not updated on writes or on errors.
- Sub-word writes (hsize<2) forward the full hwdata word and haddr unaltered. Peripherals must tolerate this.
- prdata is sampled only in ACCESS with pready=1. It is ignored otherwise, including 'x.

Test Plan:
- Write with zero wait states: NONSEQ write haddr=0x10, hwdata=0x000000A5, pready=1.
  -> psel high 2 cycles, penable in 2nd.
  -> paddr=0x10, pwdata=0xA5, hready low 3 cycles, then hready=1 with hresp=0.
- Read with 2 wait states: NONSEQ read haddr=0x20, prdata=0x3FF, pready low 2 ACCESS cycles.
  -> hready low 5 cycles, then hready=1 with hrdata=0x3FF and OKAY.
- Back-to-back pipelined transfers: write 0x0 then read 0x0 issued in the RESP cycle.
  -> second SETUP begins 2 cycles after the first RESP.
  -> psel deasserted for exactly those 2 cycles (RESP, DATA).
  -> no transfer lost.
- Slave error: pslverr=1 with pready=1 on a read.
  -> ERR1 cycle (hready=0, hresp=1), then RESP (hready=1, hresp=1).
  -> hrdata unchanged from its prior value.
- Timeout with TIMEOUT=4 and pready stuck low.
  -> exactly 4 ACCESS cycles, then psel=0 and a two-cycle ERROR response.
  -> next transfer proceeds normally.
- Reset mid-ACCESS: presetn low while penable=1.
  -> psel, penable and hresp go 0 and hready goes 1 immediately (asynchronously).
  -> after release, a new write completes correctly.
